cntr4_ctrl: RTL and testbench

Control stage for the 4-bit counter that consumes the five debounced, active-high button levels from the push-button debouncer. It detects press events and turns them into count steps, with auto-repeat on held UP/DOWN, clear, direction toggle and a free-running auto-count mode. It drives the 4-bit count value and wrap pulses to the display and LED stage. One clock domain, 390.625 kHz.

---
 rtl/cntr4_pkg.sv | 45 ++++
 rtl/cntr4_ctrl_btn_rise.sv | 31 +++
 rtl/cntr4_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cntr4_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cntr4_pkg.sv
// ---------------------------------------------------------------------------
// cntr4_pkg
// Shared definitions for the 4-bit counter control stage:
//   - auto-repeat FSM state encoding
//   - default timing constants (cycles at 390.625 kHz)
//   - timer width and timer type
//   - modulo-16 step helper returning the new count plus wrap flags
// ---------------------------------------------------------------------------
package cntr4_pkg;

    localparam int unsigned TMR_W          = 32'd19;
    localparam int unsigned DEF_REPEAT_DLY = 32'd195312;  // 500 ms
    localparam int unsigned DEF_REPEAT_INT = 32'd39062;   // 100 ms
    localparam int unsigned DEF_RUN_TICK   = 32'd390625;  // 1 s

    typedef logic [TMR_W-1:0] tmr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    typedef struct packed {
        logic [3:0] count;
        logic       carry;
        logic       borrow;
    } step_res_t;

    // One modulo-16 step; carry flags a 15->0 wrap, borrow a 0->15 wrap.
    function automatic step_res_t step4(input logic [3:0] cnt, input logic down);
        step_res_t res;
        res.carry  = 1'b0;
        res.borrow = 1'b0;
        if (down) begin
            res.count  = cnt - 4'd1;
            res.borrow = (cnt == 4'd0);
        end else begin
            res.count  = cnt + 4'd1;
            res.carry  = (cnt == 4'd15);
        end
        return res;
    endfunction

endpackage

// File: rtl/cntr4_ctrl_btn_rise.sv
// ---------------------------------------------------------------------------
// btn_rise
// Rising-edge detector for one debounced button level.
//   clk_i   in  system clock
//   rst_ni  in  asynchronous active-low reset (previous level clears to 0)
//   btn_i   in  debounced button level
//   rise_o  out high in the cycle the level is 1 and the previous level was 0
// Because the previous level resets to 0, a button already held when reset
// releases is reported as a press on the first clock.
// ---------------------------------------------------------------------------
module btn_rise (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-level register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/cntr4_ctrl.sv
// ---------------------------------------------------------------------------
// cntr4_ctrl
// Control stage of the 4-bit counter: turns debounced button levels into
// count steps (with UP/DOWN auto-repeat), clear, direction toggle and a
// free-running run mode. All outputs are registered.
//   I_CLK      in   system clock (390.625 kHz)
//   I_RESET_N  in   asynchronous active-low reset
//   I_BTNU     in   UP level: step +1 (auto-repeat while held)
//   I_BTND     in   DOWN level: step -1 (auto-repeat while held)
//   I_BTNC     in   CENTER level: clear count on press
//   I_BTNL     in   LEFT level: toggle run direction on press
//   I_BTNR     in   RIGHT level: toggle run mode on press
//   O_COUNT    out  current count (modulo 16)
//   O_DIR      out  run direction, 0 = up, 1 = down
//   O_RUN      out  run mode active
//   O_CARRY    out  one-cycle pulse on a 15->0 wrap
//   O_BORROW   out  one-cycle pulse on a 0->15 wrap
// Per-cycle priority on the count: clear > manual/repeat step > run tick.
// ---------------------------------------------------------------------------
module cntr4_ctrl
    import cntr4_pkg::*;
#(
    parameter int unsigned P_REPEAT_DLY = cntr4_pkg::DEF_REPEAT_DLY,
    parameter int unsigned P_REPEAT_INT = cntr4_pkg::DEF_REPEAT_INT,
    parameter int unsigned P_RUN_TICK   = cntr4_pkg::DEF_RUN_TICK
) (
    input  logic       I_CLK,
    input  logic       I_RESET_N,
    input  logic       I_BTNU,
    input  logic       I_BTND,
    input  logic       I_BTNC,
    input  logic       I_BTNL,
    input  logic       I_BTNR,
    output logic [3:0] O_COUNT,
    output logic       O_DIR,
    output logic       O_RUN,
    output logic       O_CARRY,
    output logic       O_BORROW
);

    localparam tmr_t TMR_ZERO = tmr_t'(32'd0);
    localparam tmr_t TMR_ONE  = tmr_t'(32'd1);
    localparam tmr_t DLY_LAST = tmr_t'(P_REPEAT_DLY - 32'd1);
    localparam tmr_t INT_LAST = tmr_t'(P_REPEAT_INT - 32'd1);
    localparam tmr_t RUN_LAST = tmr_t'(P_RUN_TICK - 32'd1);

    // Press events for the single-action buttons
    logic rise_c_s;
    logic rise_l_s;
    logic rise_r_s;

    btn_rise u_rise_c (.clk_i(I_CLK), .rst_ni(I_RESET_N), .btn_i(I_BTNC), .rise_o(rise_c_s));
    btn_rise u_rise_l (.clk_i(I_CLK), .rst_ni(I_RESET_N), .btn_i(I_BTNL), .rise_o(rise_l_s));
    btn_rise u_rise_r (.clk_i(I_CLK), .rst_ni(I_RESET_N), .btn_i(I_BTNR), .rise_o(rise_r_s));

    // Auto-repeat FSM state
    logic [1:0] key_s;
    logic       key_valid_s;
    logic [1:0] key_prev_q;
    rpt_state_e state_q, state_d;
    tmr_t       rpt_tmr_q, rpt_tmr_d;
    logic       man_step_s;
    logic       man_down_s;

    // Run mode state
    tmr_t       run_tmr_q, run_tmr_d;
    logic       run_tick_s;

    // Output registers
    logic [3:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       run_q, run_d;
    logic       carry_q, carry_d;
    logic       borrow_q, borrow_d;
    step_res_t  step_res_s;

    assign key_s       = {I_BTNU, I_BTND};
    assign key_valid_s = (key_s == 2'b10) || (key_s == 2'b01);
    assign man_down_s  = (key_s == 2'b01);

    // State and timer registers for the repeat FSM and run timer.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q    <= ST_IDLE;
            key_prev_q <= 2'b00;
            rpt_tmr_q  <= TMR_ZERO;
            run_tmr_q  <= TMR_ZERO;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_s;
            rpt_tmr_q  <= rpt_tmr_d;
            run_tmr_q  <= run_tmr_d;
        end
    end

    // Repeat FSM next state: a key change while stepping counts as a new press.
    always_comb begin
        state_d    = state_q;
        rpt_tmr_d  = rpt_tmr_q + TMR_ONE;
        man_step_s = 1'b0;
        if (!key_valid_s) begin
            // No key or both keys: never steps
            state_d   = ST_IDLE;
            rpt_tmr_d = TMR_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    man_step_s = 1'b1;
                    rpt_tmr_d  = TMR_ZERO;
                    state_d    = ST_DELAY;
                end
                ST_DELAY: begin
                    if (key_s != key_prev_q) begin
                        man_step_s = 1'b1;
                        rpt_tmr_d  = TMR_ZERO;
                        state_d    = ST_DELAY;
                    end else if (rpt_tmr_q == DLY_LAST) begin
                        man_step_s = 1'b1;
                        rpt_tmr_d  = TMR_ZERO;
                        state_d    = ST_REPEAT;
                    end else begin
                        rpt_tmr_d  = rpt_tmr_q + TMR_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (key_s != key_prev_q) begin
                        man_step_s = 1'b1;
                        rpt_tmr_d  = TMR_ZERO;
                        state_d    = ST_DELAY;
                    end else if (rpt_tmr_q == INT_LAST) begin
                        man_step_s = 1'b1;
                        rpt_tmr_d  = TMR_ZERO;
                        state_d    = ST_REPEAT;
                    end else begin
                        rpt_tmr_d  = rpt_tmr_q + TMR_ONE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rpt_tmr_d = TMR_ZERO;
                end
            endcase
        end
    end

    // Run timer: restarts on a RIGHT press, otherwise free-runs while enabled.
    always_comb begin
        run_tick_s = run_q && (run_tmr_q == RUN_LAST);
        if (rise_r_s) begin
            run_tmr_d = TMR_ZERO;
        end else if (run_q) begin
            run_tmr_d = run_tick_s ? TMR_ZERO : (run_tmr_q + TMR_ONE);
        end else begin
            run_tmr_d = run_tmr_q;
        end
    end

    // Count, direction, run flag and wrap pulses; losing events are dropped.
    always_comb begin
        cnt_d      = cnt_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        dir_d      = dir_q ^ rise_l_s;
        run_d      = run_q ^ rise_r_s;
        step_res_s = step4(cnt_q, man_step_s ? man_down_s : dir_q);
        if (rise_c_s) begin
            cnt_d = 4'd0;
        end else if (man_step_s || run_tick_s) begin
            cnt_d    = step_res_s.count;
            carry_d  = step_res_s.carry;
            borrow_d = step_res_s.borrow;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output registers.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            cnt_q    <= 4'd0;
            dir_q    <= 1'b0;
            run_q    <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            run_q    <= run_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign O_COUNT  = cnt_q;
    assign O_DIR    = dir_q;
    assign O_RUN    = run_q;
    assign O_CARRY  = carry_q;
    assign O_BORROW = borrow_q;

endmodule

// File: tb/tb_cntr4_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cntr4_ctrl
// Directed-vector bench for cntr4_ctrl with short timing parameters
// (repeat delay 10, repeat interval 4, run tick 8). Each vector drives the
// buttons on a falling edge and queues the hand-computed outputs expected
// after the following rising edge; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_cntr4_ctrl;

    localparam logic [4:0] B_0 = 5'b00000;
    localparam logic [4:0] B_U = 5'b10000;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_C = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;

    typedef struct {
        logic [3:0] cnt;
        logic       dir;
        logic       run;
        logic       cy;
        logic       bo;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnu = 1'b0, btnd = 1'b0, btnc = 1'b0, btnl = 1'b0, btnr = 1'b0;
    logic [3:0] count;
    logic       dir, run, carry, borrow;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cntr4_ctrl #(
        .P_REPEAT_DLY(10),
        .P_REPEAT_INT(4),
        .P_RUN_TICK  (8)
    ) dut (
        .I_CLK    (clk),
        .I_RESET_N(rst_n),
        .I_BTNU   (btnu),
        .I_BTND   (btnd),
        .I_BTNC   (btnc),
        .I_BTNL   (btnl),
        .I_BTNR   (btnr),
        .O_COUNT  (count),
        .O_DIR    (dir),
        .O_RUN    (run),
        .O_CARRY  (carry),
        .O_BORROW (borrow)
    );

    task automatic chk(input exp_t e);
        logic [7:0] act;
        logic [7:0] req;
        act = {count, dir, run, carry, borrow};
        req = {e.cnt, e.dir, e.run, e.cy, e.bo};
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got cnt=%0d dir=%b run=%b carry=%b borrow=%b, want cnt=%0d dir=%b run=%b carry=%b borrow=%b",
                     e.nm, $time, count, dir, run, carry, borrow, e.cnt, e.dir, e.run, e.cy, e.bo);
        end
    endtask

    task automatic vec(input logic rst, input logic [4:0] b, input logic [3:0] c,
                       input logic d, input logic r, input logic cy, input logic bo,
                       input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        {btnu, btnd, btnc, btnl, btnr} = b;
        e.cnt = c; e.dir = d; e.run = r; e.cy = cy; e.bo = bo; e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Count while UP is held from base, pressed at offset 0: steps at 0, 10, then every 4.
    function automatic logic [3:0] held_cnt(input int j, input logic [3:0] base);
        int steps;
        steps = (j < 10) ? 1 : 2 + (j - 10) / 4;
        return base + 4'(steps);
    endfunction

    // Monitor: compare the queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ea;

        // Reset state
        vec(1'b0, B_0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        vec(1'b1, B_0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset");

        // Reach 14 with DOWN presses, then UP 14->15->0 with carry
        vec(1'b1, B_D, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, "down_wrap_borrow");
        vec(1'b1, B_0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, "borrow_one_cycle");
        vec(1'b1, B_D, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, "down_to_14");
        vec(1'b1, B_0, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, "release_14");
        vec(1'b1, B_U, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, "up_14_to_15");
        vec(1'b1, B_0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, "release_15");
        vec(1'b1, B_U, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, "up_wrap_carry");
        vec(1'b1, B_0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, "carry_one_cycle");

        // Hold UP 30 cycles: steps at 0,10,14,18,22,26 -> 6
        for (int j = 0; j < 30; j++) begin
            vec(1'b1, B_U, held_cnt(j, 4'd0), 1'b0, 1'b0, 1'b0, 1'b0, "hold_up");
        end
        for (int j = 0; j < 10; j++) begin
            vec(1'b1, B_0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, "released_no_step");
        end

        // DOWN then both: no steps with K=11; K=01 steps immediately
        vec(1'b1, B_C, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_no_pulse");
        vec(1'b1, B_0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_release");
        vec(1'b1, B_D, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, "hold_down_borrow");
        for (int j = 0; j < 3; j++) begin
            vec(1'b1, B_D | B_U, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, "both_keys_no_step");
        end
        vec(1'b1, B_D, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, "k01_steps_at_once");
        vec(1'b1, B_0, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, "k00_idle");

        // Direction and run mode
        vec(1'b1, B_L, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, "dir_toggle");
        vec(1'b1, B_0, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, "dir_hold");
        vec(1'b1, B_R, 4'd14, 1'b1, 1'b1, 1'b0, 1'b0, "run_on");
        for (int j = 1; j < 8; j++) vec(1'b1, B_0, 4'd14, 1'b1, 1'b1, 1'b0, 1'b0, "run_wait1");
        vec(1'b1, B_0, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, "run_tick_down");
        for (int j = 9; j < 16; j++) vec(1'b1, B_0, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, "run_wait2");
        vec(1'b1, B_C, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, "clear_beats_tick");
        for (int j = 17; j < 24; j++) vec(1'b1, B_0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, "run_wait3");
        vec(1'b1, B_0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, "tick_borrow");
        for (int j = 25; j < 32; j++) vec(1'b1, B_0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, "run_wait4");
        vec(1'b1, B_U, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, "manual_beats_tick");
        for (int j = 33; j < 40; j++) vec(1'b1, B_0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, "run_wait5");
        vec(1'b1, B_0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, "tick_keeps_period");
        vec(1'b1, B_R, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, "run_off");
        vec(1'b1, B_0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, "run_off_hold");

        // Repeat to 9, then asynchronous reset with UP still held
        vec(1'b1, B_C, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "clear_again");
        vec(1'b1, B_0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "clear_again_rel");
        for (int j = 0; j < 40; j++) begin
            vec(1'b1, B_U, held_cnt(j, 4'd0), 1'b1, 1'b0, 1'b0, 1'b0, "repeat_to_9");
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        ea.cnt = 4'd0; ea.dir = 1'b0; ea.run = 1'b0; ea.cy = 1'b0; ea.bo = 1'b0;
        ea.nm = "async_reset";
        chk(ea);
        vec(1'b0, B_U, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "held_in_reset");
        vec(1'b1, B_U, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "resume_step");
        vec(1'b1, B_U, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "resume_delay");
        vec(1'b1, B_0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "resume_release");

        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
